// File: rtl/rtc_bus_sequencer.sv
// Sequences all transactions on the multiplexed RTC address/data bus: power-up init,
// IRQ acknowledge writes, user register writes and a periodic register read sweep.
module rtc_bus_sequencer #(
    parameter int unsigned T_PHASE  = 4,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic       irq_evt,
    output logic       wr_ack,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] ADRESS,
    output logic       BEnv_Adress,
    output logic       BEnv_Data,
    output logic       BRes_Data,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       AD
);

    localparam int unsigned CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam int unsigned TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] PH_LAST    = CW'(T_PHASE - 1);
    localparam logic [CW-1:0] PH_PRELAST = CW'(T_PHASE - 2);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP1, S_DATA, S_GAP2} state_t;
    typedef enum logic [2:0] {G_NONE, G_INIT, G_IRQ, G_USER, G_SCAN} grant_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          is_read_q;
    logic          is_user_q;
    logic [1:0]    init_cnt_q;
    logic          irq_pend_q;
    logic          irq_second_q;
    logic          wr_pend_q;
    logic [7:0]    wr_addr_q;
    logic          sweep_pend_q;
    logic [3:0]    scan_idx_q;
    logic [TW-1:0] timer_q;

    grant_t        grant_d;
    logic [7:0]    start_adr_d;
    logic [7:0]    scan_adr_c;

    // Requests seen this cycle count immediately so IDLE can start on the next edge.
    wire phase_last_c  = (cnt_q == PH_LAST);
    wire end_c         = (state_q == S_GAP2) && phase_last_c;
    wire arb_c         = (state_q == S_IDLE) || end_c;
    wire timer_wrap_c  = (timer_q == TIMER_LAST);
    wire init_req_c    = (init_cnt_q != 2'd2);
    wire irq_eff_c     = irq_pend_q | irq_evt;
    wire wr_eff_c      = wr_pend_q | wr_req;
    wire sweep_eff_c   = sweep_pend_q | timer_wrap_c;
    wire [7:0] wr_addr_eff_c = wr_req ? wr_addr : wr_addr_q;

    always_comb begin
        case (scan_idx_q)
            4'd0:    scan_adr_c = 8'h21;
            4'd1:    scan_adr_c = 8'h22;
            4'd2:    scan_adr_c = 8'h23;
            4'd3:    scan_adr_c = 8'h24;
            4'd4:    scan_adr_c = 8'h25;
            4'd5:    scan_adr_c = 8'h26;
            4'd6:    scan_adr_c = 8'h41;
            4'd7:    scan_adr_c = 8'h42;
            default: scan_adr_c = 8'h43;
        endcase
    end

    // Fixed-priority arbitration, only between transactions.
    always_comb begin
        grant_d     = G_NONE;
        start_adr_d = 8'h00;
        if (arb_c) begin
            if (init_req_c) begin
                grant_d     = G_INIT;
                start_adr_d = 8'h02;
            end else if (irq_eff_c) begin
                grant_d     = G_IRQ;
                start_adr_d = irq_second_q ? 8'h00 : 8'h01;
            end else if (wr_eff_c) begin
                grant_d     = G_USER;
                start_adr_d = wr_addr_eff_c;
            end else if (sweep_eff_c) begin
                grant_d     = G_SCAN;
                start_adr_d = scan_adr_c;
            end
        end
    end

    // Pending-request bookkeeping and the sweep timer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            init_cnt_q   <= 2'd0;
            irq_pend_q   <= 1'b0;
            irq_second_q <= 1'b0;
            wr_pend_q    <= 1'b0;
            wr_addr_q    <= 8'h00;
            sweep_pend_q <= 1'b0;
            scan_idx_q   <= 4'd0;
            timer_q      <= '0;
            init_done    <= 1'b0;
        end else begin
            timer_q      <= timer_wrap_c ? '0 : timer_q + TW'(1);
            irq_pend_q   <= irq_eff_c;
            wr_pend_q    <= wr_eff_c;
            wr_addr_q    <= wr_addr_eff_c;
            sweep_pend_q <= sweep_eff_c;
            case (grant_d)
                G_INIT: init_cnt_q <= init_cnt_q + 2'd1;
                G_IRQ: begin
                    irq_second_q <= ~irq_second_q;
                    if (irq_second_q) irq_pend_q <= irq_evt;
                end
                G_USER: wr_pend_q <= 1'b0;
                G_SCAN: begin
                    if (scan_idx_q == 4'd8) begin
                        scan_idx_q   <= 4'd0;
                        sweep_pend_q <= 1'b0;
                    end else begin
                        scan_idx_q   <= scan_idx_q + 4'd1;
                    end
                end
                default: ;
            endcase
            if (end_c && (init_cnt_q == 2'd2)) init_done <= 1'b1;
        end
    end

    // Bus phase FSM with registered strobes; a grant overrides the phase update.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_read_q   <= 1'b0;
            is_user_q   <= 1'b0;
            busy        <= 1'b0;
            ADRESS      <= 8'h00;
            BEnv_Adress <= 1'b0;
            BEnv_Data   <= 1'b0;
            BRes_Data   <= 1'b0;
            CS_n        <= 1'b1;
            RD_n        <= 1'b1;
            WR_n        <= 1'b1;
            AD          <= 1'b1;
            wr_ack      <= 1'b0;
        end else begin
            BRes_Data <= 1'b0;
            wr_ack    <= 1'b0;
            cnt_q     <= phase_last_c ? '0 : cnt_q + CW'(1);
            case (state_q)
                S_IDLE: cnt_q <= '0;
                S_ADDR: begin
                    if (phase_last_c) begin
                        state_q     <= S_GAP1;
                        CS_n        <= 1'b1;
                        WR_n        <= 1'b1;
                        AD          <= 1'b1;
                        BEnv_Adress <= 1'b0;
                    end
                end
                S_GAP1: begin
                    if (phase_last_c) begin
                        state_q   <= S_DATA;
                        CS_n      <= 1'b0;
                        RD_n      <= ~is_read_q;
                        WR_n      <= is_read_q;
                        BEnv_Data <= ~is_read_q;
                    end
                end
                S_DATA: begin
                    if (is_read_q && (cnt_q == PH_PRELAST)) BRes_Data <= 1'b1;
                    if (phase_last_c) begin
                        state_q   <= S_GAP2;
                        CS_n      <= 1'b1;
                        RD_n      <= 1'b1;
                        WR_n      <= 1'b1;
                        BEnv_Data <= 1'b0;
                    end
                end
                S_GAP2: begin
                    if (is_user_q && (cnt_q == PH_PRELAST)) wr_ack <= 1'b1;
                    if (phase_last_c) begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (grant_d != G_NONE) begin
                state_q     <= S_ADDR;
                cnt_q       <= '0;
                busy        <= 1'b1;
                ADRESS      <= start_adr_d;
                is_read_q   <= (grant_d == G_SCAN);
                is_user_q   <= (grant_d == G_USER);
                CS_n        <= 1'b0;
                AD          <= 1'b0;
                WR_n        <= 1'b0;
                RD_n        <= 1'b1;
                BEnv_Adress <= 1'b1;
                BEnv_Data   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: constant vector table, directed corner sequences and a
// random phase, all compared every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_rtc_bus_sequencer;

    localparam int unsigned T_PHASE  = 4;
    localparam int unsigned SCAN_DIV = 200;
    localparam int unsigned TX_LEN   = 4 * T_PHASE;
    localparam logic [17:0] RESET_VEC = 18'h0000F;

    logic       CLK = 1'b0;
    logic       RST;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic       irq_evt;
    logic       wr_ack, init_done, busy;
    logic [7:0] ADRESS;
    logic       BEnv_Adress, BEnv_Data, BRes_Data, CS_n, RD_n, WR_n, AD;

    rtc_bus_sequencer #(.T_PHASE(T_PHASE), .SCAN_DIV(SCAN_DIV)) dut (
        .CLK(CLK), .RST(RST), .wr_req(wr_req), .wr_addr(wr_addr), .irq_evt(irq_evt),
        .wr_ack(wr_ack), .init_done(init_done), .busy(busy), .ADRESS(ADRESS),
        .BEnv_Adress(BEnv_Adress), .BEnv_Data(BEnv_Data), .BRes_Data(BRes_Data),
        .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .AD(AD)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: a transaction is just a start offset, an address and a kind.
    bit          m_active, m_read, m_user, m_init_done;
    bit          m_irq_pend, m_irq_second, m_wr_pend, m_sweep;
    int unsigned m_off, m_init_writes, m_idx, m_timer;
    logic [7:0]  m_addr, m_wr_addr;
    logic [7:0]  scan_tab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    typedef struct {
        int unsigned cyc;
        logic        wr_req;
        logic [7:0]  wr_addr;
        logic [7:0]  adr;
        logic        cs_n, wr_n, ad, benv_d, busy, init_done, wr_ack;
    } vec_t;
    vec_t vecs[$];

    logic [7:0] got_q[$];
    int         guard, rd_low, wr_in_data, ack_cnt;
    logic       prev_ba;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [17:0] dut_vec();
        return {wr_ack, init_done, busy, ADRESS, BEnv_Adress, BEnv_Data, BRes_Data,
                CS_n, RD_n, WR_n, AD};
    endfunction

    function automatic logic [17:0] model_vec();
        int unsigned ph;
        bit a;
        ph = m_off / T_PHASE;
        a  = m_active;
        return {a && m_user && (m_off == TX_LEN - 1), m_init_done, a, m_addr,
                a && (ph == 0), a && (ph == 2) && !m_read,
                a && m_read && (m_off == 3 * T_PHASE - 1),
                !(a && (ph == 0 || ph == 2)), !(a && ph == 2 && m_read),
                !(a && (ph == 0 || (ph == 2 && !m_read))), !(a && ph == 0)};
    endfunction

    task automatic model_reset();
        m_active = 0; m_read = 0; m_user = 0; m_init_done = 0;
        m_irq_pend = 0; m_irq_second = 0; m_wr_pend = 0; m_sweep = 0;
        m_off = 0; m_init_writes = 0; m_idx = 0; m_timer = 0;
        m_addr = 8'h00; m_wr_addr = 8'h00;
    endtask

    task automatic m_start(input logic [7:0] a, input bit rd, input bit usr);
        m_active = 1; m_off = 0; m_addr = a; m_read = rd; m_user = usr;
    endtask

    task automatic model_step();
        bit fin, can, wrap;
        fin  = m_active && (m_off == TX_LEN - 1);
        can  = !m_active || fin;
        wrap = (m_timer == SCAN_DIV - 1);
        m_timer = wrap ? 0 : m_timer + 1;
        m_irq_pend = m_irq_pend || irq_evt;
        m_wr_addr  = wr_req ? wr_addr : m_wr_addr;
        m_wr_pend  = m_wr_pend || wr_req;
        m_sweep    = m_sweep || wrap;
        if (fin && m_init_writes == 2) m_init_done = 1;
        if (m_active) m_off++;
        if (fin) m_active = 0;
        if (can) begin
            if (m_init_writes < 2) begin
                m_start(8'h02, 0, 0);
                m_init_writes++;
            end else if (m_irq_pend) begin
                if (!m_irq_second) begin
                    m_start(8'h01, 0, 0);
                    m_irq_second = 1;
                end else begin
                    m_start(8'h00, 0, 0);
                    m_irq_second = 0;
                    m_irq_pend = irq_evt;
                end
            end else if (m_wr_pend) begin
                m_start(m_wr_addr, 0, 1);
                m_wr_pend = 0;
            end else if (m_sweep) begin
                m_start(scan_tab[m_idx], 1, 0);
                if (m_idx == 8) begin
                    m_idx = 0;
                    m_sweep = 0;
                end else begin
                    m_idx++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        cyc++;
        @(negedge CLK);
        check("outputs_vs_model", 32'(dut_vec()), 32'(model_vec()));
        irq_evt = 1'b0;
        wr_req  = 1'b0;
    endtask

    task automatic add_vec(input int unsigned c, input logic w, input logic [7:0] wa,
                           input logic [7:0] adr, input logic [6:0] f);
        vec_t v;
        v.cyc = c; v.wr_req = w; v.wr_addr = wa; v.adr = adr;
        {v.cs_n, v.wr_n, v.ad, v.benv_d, v.busy, v.init_done, v.wr_ack} = f;
        vecs.push_back(v);
    endtask

    task automatic do_reset_pulse();
        RST = 1'b1;
        #1;
        check("reset_state", 32'(dut_vec()), 32'(RESET_VEC));
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    initial begin
        // fields: cs_n wr_n ad benv_d busy init_done wr_ack
        add_vec(1,  1'b0, 8'h00, 8'h02, 7'b0000100);
        add_vec(4,  1'b0, 8'h00, 8'h02, 7'b0000100);
        add_vec(5,  1'b0, 8'h00, 8'h02, 7'b1110100);
        add_vec(9,  1'b0, 8'h00, 8'h02, 7'b0011100);
        add_vec(12, 1'b0, 8'h00, 8'h02, 7'b0011100);
        add_vec(13, 1'b0, 8'h00, 8'h02, 7'b1110100);
        add_vec(17, 1'b0, 8'h00, 8'h02, 7'b0000100);
        add_vec(25, 1'b0, 8'h00, 8'h02, 7'b0011100);
        add_vec(32, 1'b0, 8'h00, 8'h02, 7'b1110100);
        add_vec(33, 1'b0, 8'h00, 8'h02, 7'b1110010);
        add_vec(35, 1'b1, 8'h23, 8'h02, 7'b1110010);
        add_vec(36, 1'b0, 8'h00, 8'h23, 7'b0000110);
        add_vec(44, 1'b0, 8'h00, 8'h23, 7'b0011110);
        add_vec(50, 1'b0, 8'h00, 8'h23, 7'b1110110);
        add_vec(51, 1'b0, 8'h00, 8'h23, 7'b1110111);
        add_vec(52, 1'b0, 8'h00, 8'h23, 7'b1110010);

        RST = 1'b1; wr_req = 1'b0; wr_addr = 8'h00; irq_evt = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        do_reset_pulse();

        // Init sequence and first user write against constant vectors.
        for (int r = 0; r < vecs.size(); r++) begin
            while (cyc < int'(vecs[r].cyc)) tick();
            check("vector", 32'({ADRESS, CS_n, WR_n, AD, BEnv_Data, busy, init_done, wr_ack}),
                  32'({vecs[r].adr, vecs[r].cs_n, vecs[r].wr_n, vecs[r].ad, vecs[r].benv_d,
                       vecs[r].busy, vecs[r].init_done, vecs[r].wr_ack}));
            wr_req  = vecs[r].wr_req;
            wr_addr = vecs[r].wr_addr;
        end

        // First sweep: nine reads in order, one capture pulse each, no data-phase writes.
        rd_low = 0; wr_in_data = 0; got_q.delete();
        while (cyc < 399) begin
            tick();
            if (BRes_Data) got_q.push_back(ADRESS);
            if (!RD_n) rd_low++;
            if (!WR_n && AD) wr_in_data++;
        end
        check("sweep_reads", 32'(got_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < got_q.size(); i++)
            check("sweep_addr", 32'(got_q[i]), 32'(scan_tab[i]));
        check("sweep_rd_low", 32'(rd_low), 32'(9 * T_PHASE));
        check("sweep_wr_in_data", 32'(wr_in_data), 32'd0);

        // IRQ and user write together during read 8'h24 of the second sweep.
        guard = 0;
        while (!(BEnv_Adress && ADRESS == 8'h24) && guard < 300) begin tick(); guard++; end
        check("wait_read24", 32'(guard < 300), 32'd1);
        tick(); tick();
        irq_evt = 1'b1; wr_req = 1'b1; wr_addr = 8'h22;
        got_q.delete(); prev_ba = BEnv_Adress; guard = 0;
        while (got_q.size() < 5 && guard < 200) begin
            tick(); guard++;
            if (BEnv_Adress && !prev_ba) got_q.push_back(ADRESS);
            prev_ba = BEnv_Adress;
        end
        check("preempt_count", 32'(got_q.size()), 32'd5);
        if (got_q.size() == 5) begin
            check("preempt_0", 32'(got_q[0]), 32'h01);
            check("preempt_1", 32'(got_q[1]), 32'h00);
            check("preempt_2", 32'(got_q[2]), 32'h22);
            check("preempt_3", 32'(got_q[3]), 32'h25);
            check("preempt_4", 32'(got_q[4]), 32'h26);
        end

        // Two user writes while busy collapse into one write of the last address.
        guard = 0;
        while (!(BEnv_Adress && ADRESS == 8'h21) && guard < 400) begin tick(); guard++; end
        check("wait_read21", 32'(guard < 400), 32'd1);
        tick(); tick();
        wr_req = 1'b1; wr_addr = 8'h21;
        tick(); tick();
        wr_req = 1'b1; wr_addr = 8'h26;
        got_q.delete(); prev_ba = BEnv_Adress; guard = 0; ack_cnt = 0;
        while (got_q.size() < 2 && guard < 200) begin
            tick(); guard++;
            if (wr_ack) ack_cnt++;
            if (BEnv_Adress && !prev_ba) got_q.push_back(ADRESS);
            prev_ba = BEnv_Adress;
        end
        check("merge_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("merge_write", 32'(got_q[0]), 32'h26);
            check("merge_resume", 32'(got_q[1]), 32'h22);
        end
        check("merge_acks", 32'(ack_cnt), 32'd1);

        // Reset in the middle of a DATA phase.
        guard = 0;
        while (!(CS_n == 1'b0 && AD == 1'b1) && guard < 100) begin tick(); guard++; end
        check("wait_data", 32'(guard < 100), 32'd1);
        do_reset_pulse();
        tick();
        check("init_restart", 32'({ADRESS, CS_n, AD}), 32'({8'h02, 1'b0, 1'b0}));
        guard = 0;
        while (!BRes_Data && guard < 400) begin tick(); guard++; end
        check("scan_restart", 32'(ADRESS), 32'h21);

        // Random traffic against the model, with one reset in the middle.
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset_pulse();
            irq_evt = ($urandom_range(0, 39) == 0);
            wr_req  = ($urandom_range(0, 24) == 0);
            wr_addr = 8'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
